// File: rtl/keypad_scan_pkg.sv
// Shared types and constants for the 4x4 keypad scanner and its debounce logic.
package keypad_scan_pkg;

    // Debounce FSM states
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_PRESSED  = 2'd2,
        ST_RELEASE  = 2'd3
    } state_t;

    // Classification of one full 16-key scan
    typedef enum logic [1:0] {
        RES_NONE   = 2'd0,
        RES_SINGLE = 2'd1,
        RES_MULTI  = 2'd2
    } scan_class_t;

    // Row drive pattern after reset: row 0 driven low
    localparam logic [3:0] ROW_RESET = 4'b1110;

    // Key map, flag index = row*4 + col
    //   r0: 1 2 3 A   r1: 4 5 6 B   r2: 7 8 9 C   r3: E(*) 0 F(#) D
    function automatic logic [3:0] key_map(input logic [3:0] idx);
        logic [3:0] code;
        case (idx)
            4'd0:    code = 4'h1;
            4'd1:    code = 4'h2;
            4'd2:    code = 4'h3;
            4'd3:    code = 4'hA;
            4'd4:    code = 4'h4;
            4'd5:    code = 4'h5;
            4'd6:    code = 4'h6;
            4'd7:    code = 4'hB;
            4'd8:    code = 4'h7;
            4'd9:    code = 4'h8;
            4'd10:   code = 4'h9;
            4'd11:   code = 4'hC;
            4'd12:   code = 4'hE;
            4'd13:   code = 4'h0;
            4'd14:   code = 4'hF;
            default: code = 4'hD;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/keypad_scan_row_scanner.sv
// Drives the keypad rows in rotation, samples the synchronised columns at the
// end of each row dwell and classifies every completed 16-key scan.
module keypad_row_scanner
    import keypad_scan_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  col,
    output logic [3:0]  row,
    output logic        scan_done,
    output scan_class_t scan_class,
    output logic [3:0]  scan_code
);

    localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] DWELL_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DWELL_ONE  = CW'(1);

    logic [3:0]    col_meta;
    logic [3:0]    col_sync;
    logic [CW-1:0] dwell;
    logic [1:0]    row_idx;
    logic [11:0]   flags;
    logic          sample;
    logic [15:0]   live;
    logic [4:0]    hits;
    logic [3:0]    hit_idx;

    assign sample    = (dwell == DWELL_LAST);
    assign scan_done = sample && (row_idx == 2'd3);

    // Two-flop synchroniser for the asynchronous column inputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_meta <= '1;
            col_sync <= '1;
        end else begin
            col_meta <= col;
            col_sync <= col_meta;
        end
    end

    // Dwell counter, row rotation and per-row sampling of active columns
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dwell   <= '0;
            row_idx <= '0;
            row     <= ROW_RESET;
            flags   <= '0;
        end else if (sample) begin
            dwell   <= '0;
            row_idx <= row_idx + 2'd1;
            row     <= {row[2:0], row[3]};
            case (row_idx)
                2'd0:    flags[3:0]  <= ~col_sync;
                2'd1:    flags[7:4]  <= ~col_sync;
                2'd2:    flags[11:8] <= ~col_sync;
                default: ;
            endcase
        end else begin
            dwell <= dwell + DWELL_ONE;
        end
    end

    // Row 3 is classified straight from the live synchronised columns on its
    // sample cycle, so only rows 0-2 need stored flags and the result is
    // available on the scan-end cycle itself.
    always_comb begin
        live       = {~col_sync, flags};
        hits       = '0;
        hit_idx    = '0;
        scan_class = RES_NONE;
        for (int unsigned i = 0; i < 16; i++) begin
            if (live[i]) begin
                hits    = hits + 5'd1;
                hit_idx = 4'(i);
            end
        end
        if (hits == 5'd1)
            scan_class = RES_SINGLE;
        else if (hits != 5'd0)
            scan_class = RES_MULTI;
    end

    assign scan_code = key_map(hit_idx);

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad front end: row scanning plus a per-scan debounce FSM that
// emits one key_valid strobe per accepted press.
module keypad_scan
    import keypad_scan_pkg::*;
#(
    parameter int unsigned SCAN_DIV       = 50000,
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       SW0,
    input  logic [3:0] col,
    output logic [3:0] row,
    output logic [3:0] key,
    output logic       key_valid,
    output logic       key_held
);

    localparam int unsigned DW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_SCANS);
    localparam logic [DW-1:0] DB_ONE  = DW'(1);

    logic        scan_done;
    scan_class_t scan_class;
    logic [3:0]  scan_code;
    state_t      state;
    logic [3:0]  cand;
    logic [DW-1:0] cnt;
    logic        is_single;

    keypad_row_scanner #(
        .SCAN_DIV (SCAN_DIV)
    ) u_scanner (
        .clk        (clk),
        .rst_n      (SW0),
        .col        (col),
        .row        (row),
        .scan_done  (scan_done),
        .scan_class (scan_class),
        .scan_code  (scan_code)
    );

    assign is_single = (scan_class == RES_SINGLE);

    // Debounce FSM, stepped once per completed scan, with registered outputs
    always_ff @(posedge clk or negedge SW0) begin
        if (!SW0) begin
            state     <= ST_IDLE;
            cand      <= '0;
            cnt       <= '0;
            key       <= '0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            if (scan_done) begin
                case (state)
                    ST_IDLE: begin
                        if (is_single) begin
                            state <= ST_DEBOUNCE;
                            cand  <= scan_code;
                            cnt   <= DB_ONE;
                        end
                    end
                    ST_DEBOUNCE: begin
                        if (is_single && scan_code == cand) begin
                            if (cnt + DB_ONE == DB_LAST) begin
                                state     <= ST_PRESSED;
                                key       <= cand;
                                key_valid <= 1'b1;
                                key_held  <= 1'b1;
                                cnt       <= '0;
                            end else begin
                                cnt <= cnt + DB_ONE;
                            end
                        end else if (is_single) begin
                            cand <= scan_code;
                            cnt  <= DB_ONE;
                        end else begin
                            state <= ST_IDLE;
                            cnt   <= '0;
                        end
                    end
                    ST_PRESSED: begin
                        if (!(is_single && scan_code == key)) begin
                            state <= ST_RELEASE;
                            cnt   <= DB_ONE;
                        end
                    end
                    ST_RELEASE: begin
                        if (is_single && scan_code == key) begin
                            state <= ST_PRESSED;
                            cnt   <= '0;
                        end else if (cnt + DB_ONE == DB_LAST) begin
                            state    <= ST_IDLE;
                            key_held <= 1'b0;
                            cnt      <= '0;
                        end else begin
                            cnt <= cnt + DB_ONE;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
